// File: rtl/mul.sv
// ============================================================================
//  Module   : mul
//  Purpose  : Sequential signed fixed-point multiplier. Radix-2 shift-add on
//             magnitudes, sign restore and saturation on the final edge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul #(
    parameter int DATA_WIDTH = 16,
    parameter int BIN_POS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  ready,
    output logic                  complete,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  overflow
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam int c_ACC_W = 2 * DATA_WIDTH;

    localparam logic [c_CNT_W-1:0]    c_LAST     = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_ACC_W-1:0]    c_MAG_LIM  = {{DATA_WIDTH{1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_POS_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_NEG_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_mag_a;
    logic [DATA_WIDTH-1:0] r_mag_b;
    logic                  r_neg;
    logic [c_ACC_W-1:0]    r_acc;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_ready;
    logic                  r_complete;
    logic [DATA_WIDTH-1:0] r_out;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_abs_a;
    logic [DATA_WIDTH-1:0] w_abs_b;
    logic [c_ACC_W-1:0]    w_pp;
    logic [c_ACC_W-1:0]    w_mag;
    logic [DATA_WIDTH-1:0] w_neg_mag;

    // Negating the most negative value in DATA_WIDTH unsigned bits yields
    // exactly 2^(DW-1), which is the correct magnitude.
    assign w_abs_a   = a[DATA_WIDTH-1] ? (~a + c_ONE) : a;
    assign w_abs_b   = b[DATA_WIDTH-1] ? (~b + c_ONE) : b;
    assign w_pp      = {{DATA_WIDTH{1'b0}}, r_mag_a} << r_cnt;
    assign w_mag     = r_acc >> BIN_POS;
    assign w_neg_mag = ~w_mag[DATA_WIDTH-1:0] + c_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_neg      <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ready    <= 1'b1;
            r_complete <= 1'b0;
            r_out      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_complete <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mag_a <= w_abs_a;
                        r_mag_b <= w_abs_b;
                        r_neg   <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (r_mag_b[r_cnt]) begin
                        r_acc <= r_acc + w_pp;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!r_neg && (w_mag >= c_MAG_LIM)) begin
                        r_out      <= c_POS_MAX;
                        r_overflow <= 1'b1;
                    end else if (r_neg && (w_mag > c_MAG_LIM)) begin
                        r_out      <= c_NEG_MIN;
                        r_overflow <= 1'b1;
                    end else begin
                        // Negating a zero magnitude gives zero, so -0 never appears.
                        r_out      <= r_neg ? w_neg_mag : w_mag[DATA_WIDTH-1:0];
                        r_overflow <= 1'b0;
                    end
                    r_complete <= 1'b1;
                    r_ready    <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign complete = r_complete;
    assign out      = r_out;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
